ibuffer_compact: RTL and testbench

Parametrised instruction buffer between the fetch unit and the decoder. It accepts one fetch packet per cycle of up to FETCH_WIDTH slots with a slot-valid mask. It packs only the valid slots, in lane order, into a circular entry array. It presents up to DECODE_WIDTH oldest entries per cycle and pops a variable number of them, chosen by the consumer, so decode need not take a whole packet at once.

---
 rtl/ibuffer_compact.sv | 115 +++++++++++
 tb/tb_ibuffer_compact.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ibuffer_compact.sv
// ibuffer_compact: packs valid fetch slots into a circular buffer and presents up to DECODE_WIDTH oldest entries (optional perf counters under IBUF_PERF_EN)
module ibuffer_compact #(
   parameter int ILEN         = 32,
   parameter int PLEN         = 32,
   parameter int FETCH_WIDTH  = 4,
   parameter int DECODE_WIDTH = 4,
   parameter int DEPTH        = 16,
   parameter int FTQ_ID_W     = 2,
   parameter int EPOCH_W      = 3
`ifdef IBUF_PERF_EN
   , parameter int PERF_CNT_W = 32
`endif
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 flush_i,
   input  logic                                 fe_valid_i,
   output logic                                 fe_ready_o,
   input  logic [FETCH_WIDTH*ILEN-1:0]          fe_instrs_i,
   input  logic [PLEN-1:0]                      fe_pc_i,
   input  logic [FETCH_WIDTH-1:0]               fe_slot_valid_i,
   input  logic [FETCH_WIDTH*PLEN-1:0]          fe_pred_npc_i,
   input  logic [FETCH_WIDTH*FTQ_ID_W-1:0]      fe_ftq_id_i,
   input  logic [FETCH_WIDTH*EPOCH_W-1:0]       fe_fetch_epoch_i,
   output logic [DECODE_WIDTH-1:0]              out_valid_o,
   output logic [DECODE_WIDTH*ILEN-1:0]         out_instr_o,
   output logic [DECODE_WIDTH*PLEN-1:0]         out_pc_o,
   output logic [DECODE_WIDTH*PLEN-1:0]         out_pred_npc_o,
   output logic [DECODE_WIDTH*FTQ_ID_W-1:0]     out_ftq_id_o,
   output logic [DECODE_WIDTH*EPOCH_W-1:0]      out_epoch_o,
   input  logic [$clog2(DECODE_WIDTH+1)-1:0]    deq_cnt_i,
   output logic [$clog2(DEPTH+1)-1:0]           count_o
`ifdef IBUF_PERF_EN
   , output logic [PERF_CNT_W-1:0]              perf_full_cycles_o
   , output logic [PERF_CNT_W-1:0]              perf_empty_cycles_o
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [ILEN-1:0]     mem_instr [DEPTH];
   logic [PLEN-1:0]     mem_pc    [DEPTH];
   logic [PLEN-1:0]     mem_npc   [DEPTH];
   logic [FTQ_ID_W-1:0] mem_ftq   [DEPTH];
   logic [EPOCH_W-1:0]  mem_epoch [DEPTH];
   logic [PW-1:0]       head, tail;
   logic [CW-1:0]       count, n, avail, d;
   logic [PW-1:0]       off [FETCH_WIDTH];
   logic                enq;
   // exclusive prefix popcount gives each valid slot its packed offset from tail
   always_comb begin
      n = '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         off[j] = n[PW-1:0];
         n = n + CW'(fe_slot_valid_i[j]);
      end
   end
   assign fe_ready_o = count <= CW'(DEPTH - FETCH_WIDTH);
   assign enq        = fe_valid_i && fe_ready_o && !flush_i;
   assign avail      = count < CW'(DECODE_WIDTH) ? count : CW'(DECODE_WIDTH);
   assign d          = CW'(deq_cnt_i) < avail ? CW'(deq_cnt_i) : avail;
   assign count_o    = count;
   genvar k;
   generate
      for (k = 0; k < DECODE_WIDTH; k++) begin : g_lane
         assign out_valid_o[k]                        = CW'(k) < avail;
         assign out_instr_o[k*ILEN +: ILEN]           = mem_instr[head + PW'(k)];
         assign out_pc_o[k*PLEN +: PLEN]              = mem_pc[head + PW'(k)];
         assign out_pred_npc_o[k*PLEN +: PLEN]        = mem_npc[head + PW'(k)];
         assign out_ftq_id_o[k*FTQ_ID_W +: FTQ_ID_W]  = mem_ftq[head + PW'(k)];
         assign out_epoch_o[k*EPOCH_W +: EPOCH_W]     = mem_epoch[head + PW'(k)];
      end
   endgenerate
   // pointers and occupancy; flush wins over enqueue and dequeue
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(d);
         tail  <= enq ? tail + PW'(n) : tail;
         count <= count + (enq ? n : '0) - d;
      end
   end
   // write each valid slot to its packed position; entry storage is not reset
   always_ff @(posedge clk_i) begin
      if (enq) begin
         for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (fe_slot_valid_i[j]) begin
               mem_instr[tail + off[j]] <= fe_instrs_i[j*ILEN +: ILEN];
               mem_pc[tail + off[j]]    <= fe_pc_i + PLEN'(4*j);
               mem_npc[tail + off[j]]   <= fe_pred_npc_i[j*PLEN +: PLEN];
               mem_ftq[tail + off[j]]   <= fe_ftq_id_i[j*FTQ_ID_W +: FTQ_ID_W];
               mem_epoch[tail + off[j]] <= fe_fetch_epoch_i[j*EPOCH_W +: EPOCH_W];
            end
         end
      end
   end
`ifdef IBUF_PERF_EN
   // saturating stall/empty cycle counters, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_full_cycles_o  <= '0;
         perf_empty_cycles_o <= '0;
      end else begin
         if (fe_valid_i && !fe_ready_o && !(&perf_full_cycles_o)) perf_full_cycles_o <= perf_full_cycles_o + 1'b1;
         if (count == '0 && !(&perf_empty_cycles_o)) perf_empty_cycles_o <= perf_empty_cycles_o + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_ibuffer_compact.sv
// tb_ibuffer_compact: scoreboard bench for ibuffer_compact with a queue-based reference model (checks perf ports when IBUF_PERF_EN is defined)
module tb_ibuffer_compact;
   localparam int DEPTH = 16, FW = 4, DW = 4;
   typedef struct {
      logic [31:0] instr, pc, npc;
      logic [1:0]  ftq;
      logic [2:0]  ep;
   } ent_t;
   logic          clk = 0, rst_ni = 0, flush = 0, fe_valid = 0, fe_ready;
   logic [127:0]  instrs = '0, npcs = '0, out_instr, out_pc, out_npc;
   logic [31:0]   pc = '0;
   logic [3:0]    mask = '0, out_valid;
   logic [7:0]    ftq = '0, out_ftq;
   logic [11:0]   ep = '0, out_ep;
   logic [2:0]    deq = '0;
   logic [4:0]    count;
`ifdef IBUF_PERF_EN
   logic [31:0]   perf_full, perf_empty;
`endif
   ent_t q[$], pend[$];
   bit   p_acc = 0, p_flush = 0, p_full = 0;
   int   p_size = 0, errs = 0, checks = 0, m_full = 0, m_empty = 0;

   ibuffer_compact dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .fe_valid_i(fe_valid), .fe_ready_o(fe_ready),
      .fe_instrs_i(instrs), .fe_pc_i(pc), .fe_slot_valid_i(mask), .fe_pred_npc_i(npcs),
      .fe_ftq_id_i(ftq), .fe_fetch_epoch_i(ep), .out_valid_o(out_valid), .out_instr_o(out_instr),
      .out_pc_o(out_pc), .out_pred_npc_o(out_npc), .out_ftq_id_o(out_ftq), .out_epoch_o(out_ep),
      .deq_cnt_i(deq), .count_o(count)
`ifdef IBUF_PERF_EN
      , .perf_full_cycles_o(perf_full), .perf_empty_cycles_o(perf_empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // apply the effect of the edge just passed to the model
   task automatic commit();
      if (p_flush) q.delete();
      else if (p_acc) foreach (pend[i]) q.push_back(pend[i]);
      if (p_full) m_full++;
      if (p_size == 0) m_empty++;
   endtask

   // drive one cycle of stimulus and push what it will enqueue
   task automatic drive(bit v, logic [3:0] m, logic [31:0] p, int dq, bit fl);
      @(posedge clk); #1;
      commit();
      pend.delete();
      instrs = {$urandom, $urandom, $urandom, $urandom};
      npcs   = {$urandom, $urandom, $urandom, $urandom};
      ftq    = 8'($urandom);
      ep     = 12'($urandom);
      fe_valid = v; mask = m; pc = p; deq = 3'(dq); flush = fl;
      p_size  = q.size();
      p_acc   = v && (DEPTH - q.size() >= FW);
      p_full  = v && !(DEPTH - q.size() >= FW);
      p_flush = fl;
      for (int j = 0; j < FW; j++)
         if (m[j]) pend.push_back('{instrs[j*32 +: 32], p + 32'(4*j), npcs[j*32 +: 32], ftq[j*2 +: 2], ep[j*3 +: 3]});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_ni = 0; fe_valid = 0; flush = 0; deq = 0; mask = 0;
      q.delete(); pend.delete();
      p_acc = 0; p_flush = 0; p_full = 0; m_full = 0; m_empty = 0;
      #2;
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ready", 32'(fe_ready), 1);
      @(posedge clk); #1;
      rst_ni = 1;
      p_size = 0;
   endtask

   // monitor: compare presented lanes with the scoreboard, then retire what decode takes
   always @(negedge clk) begin
      int n, d;
      n = q.size() < DW ? q.size() : DW;
      check("count", 32'(count), 32'(q.size()));
      check("ready", 32'(fe_ready), 32'(q.size() <= DEPTH - FW));
      check("valid", 32'(out_valid), (32'd1 << n) - 1);
      for (int k = 0; k < n; k++) begin
         check($sformatf("instr%0d", k), out_instr[k*32 +: 32], q[k].instr);
         check($sformatf("pc%0d", k), out_pc[k*32 +: 32], q[k].pc);
         check($sformatf("npc%0d", k), out_npc[k*32 +: 32], q[k].npc);
         check($sformatf("ftq%0d", k), 32'(out_ftq[k*2 +: 2]), 32'(q[k].ftq));
         check($sformatf("epoch%0d", k), 32'(out_ep[k*3 +: 3]), 32'(q[k].ep));
      end
`ifdef IBUF_PERF_EN
      check("perf_full", perf_full, 32'(m_full));
      check("perf_empty", perf_empty, 32'(m_empty));
`endif
      d = int'(deq) < n ? int'(deq) : n;
      if (rst_ni && !flush) repeat (d) void'(q.pop_front());
   end

   initial begin
      do_reset();
      repeat (5) drive(0, 0, 0, 0, 0);
      drive(1, 4'hF, 32'h8000_0000, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(1, 4'b1010, 32'h100, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      repeat (3) drive(1, 4'hF, 32'h1000, 0, 0);
      drive(1, 4'b0001, 32'h2000, 0, 0);
      drive(1, 4'hF, 32'h3000, 4, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      repeat (3) drive(1, 4'hF, 32'h4000, 0, 0);
      drive(1, 4'b0011, 32'h5000, 0, 0);
      repeat (3) drive(0, 0, 0, 4, 0);
      drive(0, 0, 0, 2, 0);
      drive(1, 4'hF, 32'h6000, 0, 0);
      drive(1, 4'b0011, 32'h7000, 0, 0);
      drive(0, 0, 0, 3, 0);
      drive(0, 0, 0, 3, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(1, 4'b0011, 32'h8000, 0, 0);
      drive(0, 0, 0, 4, 0);
      drive(1, 4'b0011, 32'h9000, 0, 0);
      drive(1, 4'hF, 32'hA000, 4, 1);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      repeat (4) drive(1, 4'hF, 32'hB000, 0, 0);
      repeat (10) drive(1, 4'hF, 32'hC000, 0, 0);
      drive(0, 0, 0, 0, 0);
      repeat (30) drive($urandom % 4 != 0, 4'($urandom), $urandom & ~32'h3, $urandom % 2, 0);
      do_reset();
      repeat (5) drive(0, 0, 0, 0, 0);
      repeat (1000) drive($urandom % 4 != 0, 4'($urandom), $urandom & ~32'h3, $urandom % 3, $urandom % 40 == 0);
      repeat (1000) drive($urandom % 3 != 0, 4'($urandom), $urandom & ~32'h3, $urandom % 6, $urandom % 40 == 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
